// File: rtl/mem_wb_pkg.sv
// Shared pipeline definitions for the 64-bit RISC-V style core.
// Widths and the MEM/WB bundle used by neighbouring stages.
package mem_wb_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic                  RegWrite;
      logic                  MemtoReg;
      logic [XLEN-1:0]       data;
      logic [XLEN-1:0]       alu;
      logic [REG_ADDR_W-1:0] rd;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// Generic pipeline register with a synchronous active-low clear.
// Loads every cycle; clear wins over the incoming data.
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // capture d each edge, or zero it when clear is sampled low
   always_ff @(posedge clk) begin
      if (!rstN) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: holds write-back controls, load data,
// ALU result and destination index for one cycle.
module mem_wb #(
   parameter int DATA_W     = mem_wb_pkg::XLEN,
   parameter int REG_ADDR_W = mem_wb_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RegWrite,
   input  logic                  MemtoReg,
   input  logic [DATA_W-1:0]     Dataout_Memory,
   input  logic [DATA_W-1:0]     AluOut_in,
   input  logic [REG_ADDR_W-1:0] Rd_in,
   output logic                  RegWrite_Out,
   output logic                  MemtoReg_Out,
   output logic [DATA_W-1:0]     DataOut,
   output logic [DATA_W-1:0]     AluOut,
   output logic [REG_ADDR_W-1:0] Rd_out
);

   localparam int W = 2 + 2 * DATA_W + REG_ADDR_W;

   logic [W-1:0] stageD;
   logic [W-1:0] stageQ;

   // pack the fields in mem_wb_t order
   always_comb begin
      stageD = {RegWrite, MemtoReg, Dataout_Memory, AluOut_in, Rd_in};
   end

   pipe_reg #(
      .W (W)
   ) uStage (
      .clk  (clk),
      .rstN (reset),
      .d    (stageD),
      .q    (stageQ)
   );

   // unpack the registered bundle onto the write-back outputs
   always_comb begin
      {RegWrite_Out, MemtoReg_Out, DataOut, AluOut, Rd_out} = stageQ;
   end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for the MEM/WB pipeline register.
// Checks reset, 1-cycle capture, corners and sync reset behaviour.
module tb_mem_wb;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic        MemtoReg;
   logic [63:0] Dataout_Memory;
   logic [63:0] AluOut_in;
   logic [4:0]  Rd_in;
   logic        RegWrite_Out;
   logic        MemtoReg_Out;
   logic [63:0] DataOut;
   logic [63:0] AluOut;
   logic [4:0]  Rd_out;

   int total = 0;
   int bad   = 0;

   mem_wb dut (
      .clk            (clk),
      .reset          (reset),
      .RegWrite       (RegWrite),
      .MemtoReg       (MemtoReg),
      .Dataout_Memory (Dataout_Memory),
      .AluOut_in      (AluOut_in),
      .Rd_in          (Rd_in),
      .RegWrite_Out   (RegWrite_Out),
      .MemtoReg_Out   (MemtoReg_Out),
      .DataOut        (DataOut),
      .AluOut         (AluOut),
      .Rd_out         (Rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkAll(input string tag, input logic rw, input logic m2r,
                         input logic [63:0] dat, input logic [63:0] alu,
                         input logic [4:0] rd);
      chk({tag, ".RegWrite_Out"}, {63'd0, RegWrite_Out}, {63'd0, rw});
      chk({tag, ".MemtoReg_Out"}, {63'd0, MemtoReg_Out}, {63'd0, m2r});
      chk({tag, ".DataOut"}, DataOut, dat);
      chk({tag, ".AluOut"}, AluOut, alu);
      chk({tag, ".Rd_out"}, {59'd0, Rd_out}, {59'd0, rd});
   endtask

   task automatic drive(input logic rw, input logic m2r,
                        input logic [63:0] dat, input logic [63:0] alu,
                        input logic [4:0] rd);
      RegWrite       = rw;
      MemtoReg       = m2r;
      Dataout_Memory = dat;
      AluOut_in      = alu;
      Rd_in          = rd;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h1234, 5'd7);

      // reset held low for two edges with busy inputs
      @(posedge clk); #1;
      chkAll("rst1", 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
      @(posedge clk); #1;
      chkAll("rst2", 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);

      // release and present first transfer
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h42, 5'd10);
      #1;
      chkAll("preEdge", 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
      @(posedge clk); #1;
      chkAll("first", 1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h42, 5'd10);

      // back-to-back transfers, held between edges
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk("holdRd", {59'd0, Rd_out},
             (i == 1) ? 64'd10 : 64'(i - 1));
         drive(i[0], ~i[0], 64'(i * 100), 64'(i * 16), 5'(i));
         #1;
         chk("holdAlu", AluOut, (i == 1) ? 64'h42 : 64'((i - 1) * 16));
         @(posedge clk); #1;
         chkAll("stream", i[0], ~i[0], 64'(i * 100), 64'(i * 16), 5'(i));
      end

      // extreme values
      @(negedge clk);
      drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 5'h1F);
      @(posedge clk); #1;
      chkAll("corner", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 5'h1F);

      // Rd of zero passes through
      @(negedge clk);
      drive(1'b1, 1'b0, 64'h0, 64'h7, 5'd0);
      @(posedge clk); #1;
      chkAll("rdZero", 1'b1, 1'b0, 64'h0, 64'h7, 5'd0);

      // mid-operation reset kills in-flight write
      @(negedge clk);
      drive(1'b1, 1'b0, 64'h55, 64'h66, 5'd5);
      @(posedge clk); #1;
      chkAll("load5", 1'b1, 1'b0, 64'h55, 64'h66, 5'd5);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 1'b1, 64'h77, 64'h88, 5'd9);
      @(posedge clk); #1;
      chkAll("midRst", 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 1'b0, 64'h99, 64'hAA, 5'd6);
      @(posedge clk); #1;
      chkAll("resume", 1'b1, 1'b0, 64'h99, 64'hAA, 5'd6);

      // reset pulse between edges must be ignored
      @(negedge clk);
      drive(1'b0, 1'b1, 64'h1111, 64'h2222, 5'd12);
      @(posedge clk); #1;
      chkAll("preGlitch", 1'b0, 1'b1, 64'h1111, 64'h2222, 5'd12);
      #1 reset = 1'b0;
      #2;
      chkAll("inGlitch", 1'b0, 1'b1, 64'h1111, 64'h2222, 5'd12);
      reset = 1'b1;
      drive(1'b1, 1'b0, 64'h3333, 64'h4444, 5'd13);
      @(posedge clk); #1;
      chkAll("postGlitch", 1'b1, 1'b0, 64'h3333, 64'h4444, 5'd13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
